keypad_matrix_emulator: RTL and testbench

KEYPAD_MATRIX_EMULATOR -- requirements
Module: keypad_matrix_emulator

---
 rtl/keypad_matrix_emulator.sv | 149 ++++++++++++++
 tb/tb_keypad_matrix_emulator.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_emulator.sv
// Emulates a single key of a 4x4 passive keypad matrix: queued press commands are
// played out as bounce / hold / gap contact phases seen by an external row scanner.
module keypad_matrix_emulator #(
   parameter int unsigned HOLD_CYCLES   = 100000,
   parameter int unsigned GAP_CYCLES    = 50000,
   parameter int unsigned BOUNCE_CYCLES = 0,
   parameter int unsigned BOUNCE_PERIOD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] rows_in,
   output logic [3:0] cols_out,
   input  logic       cmd_valid,
   input  logic [3:0] cmd_key,
   output logic       cmd_ready,
   input  logic       flush,
   output logic       busy,
   output logic [3:0] active_key,
   output logic       contact,
   output logic       key_done
);

   localparam logic [19:0] HOLD_LD = 20'(HOLD_CYCLES);
   localparam logic [19:0] GAP_LD  = 20'(GAP_CYCLES);
   localparam logic [19:0] BNC_LD  = 20'(BOUNCE_CYCLES);
   localparam logic [19:0] PER_LD  = 20'(BOUNCE_PERIOD);

   typedef enum logic [1:0] {S_IDLE, S_BOUNCE, S_HOLD, S_GAP} state_t;

   state_t      state_q, state_d;
   logic [19:0] cnt_q, cnt_d;
   logic [19:0] per_q, per_d;
   logic        bnc_q, bnc_d;
   logic [3:0]  key_q, key_d;

   logic [3:0]  fifo_mem [4];
   logic [1:0]  wr_ptr_q, rd_ptr_q;
   logic [2:0]  count_q;
   logic        fifo_full, fifo_empty, push, pop;

   assign fifo_full  = (count_q == 3'd4);
   assign fifo_empty = (count_q == 3'd0);
   // Readiness uses the pre-edge fill level, so a same-cycle pop never frees a full FIFO.
   assign cmd_ready  = !fifo_full && !flush;
   assign push       = cmd_valid && cmd_ready;
   assign pop        = (state_q == S_IDLE) && !fifo_empty && !flush;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= cmd_key;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
      end else if (flush) begin
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
         count_q <= count_q + {2'b00, push} - {2'b00, pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 20'd0;
         per_q   <= 20'd0;
         bnc_q   <= 1'b0;
         key_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         bnc_q   <= bnc_d;
         key_q   <= key_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = (cnt_q != 20'd0) ? cnt_q - 20'd1 : cnt_q;
      per_d    = per_q;
      bnc_d    = bnc_q;
      key_d    = key_q;
      key_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = cnt_q;
            if (pop) begin
               key_d = fifo_mem[rd_ptr_q];
               if (BOUNCE_CYCLES == 0) begin
                  state_d = S_HOLD;
                  cnt_d   = HOLD_LD;
               end else begin
                  state_d = S_BOUNCE;
                  cnt_d   = BNC_LD;
                  per_d   = PER_LD;
                  bnc_d   = 1'b1;
               end
            end
         end
         S_BOUNCE: begin
            if (flush) begin
               state_d = S_GAP;
               cnt_d   = GAP_LD;
            end else if (cnt_q == 20'd1) begin
               state_d = S_HOLD;
               cnt_d   = HOLD_LD;
            end else if (per_q == 20'd1) begin
               per_d = PER_LD;
               bnc_d = !bnc_q;
            end else begin
               per_d = per_q - 20'd1;
            end
         end
         S_HOLD: begin
            if (flush || cnt_q == 20'd1) begin
               state_d = S_GAP;
               cnt_d   = GAP_LD;
            end
         end
         S_GAP: begin
            // Return through IDLE guarantees a released cycle before the next pop.
            if (cnt_q == 20'd1) begin
               key_done = 1'b1;
               state_d  = S_IDLE;
               key_d    = 4'd0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign contact    = (state_q == S_HOLD) || ((state_q == S_BOUNCE) && bnc_q);
   assign busy       = (state_q != S_IDLE) || !fifo_empty;
   assign active_key = key_q;

   // Passive switch: the selected column follows its row drive with no clock latency.
   always_comb begin
      cols_out = 4'b1111;
      if (contact && !rows_in[key_q[3:2]]) cols_out[key_q[1:0]] = 1'b0;
   end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Bench for keypad_matrix_emulator: two instances (no bounce / 6-cycle bounce) share
// stimulus and are checked every cycle against a press-timeline reference model.
module tb_keypad_matrix_emulator;

   localparam int H = 8;
   localparam int G = 4;
   localparam int P = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] rows_in = 4'hF;
   logic       cmd_valid = 1'b0;
   logic [3:0] cmd_key = 4'd0;
   logic       flush = 1'b0;

   logic [3:0] cols_o [2];
   logic       rdy_o [2];
   logic       busy_o [2];
   logic [3:0] ak_o [2];
   logic       contact_o [2];
   logic       kd_o [2];

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   // Reference model: per instance, whether a press is in progress, the number of
   // cycles since it began (t), its key, and the queued commands.
   logic       m_in [2];
   int         m_t [2];
   logic [3:0] m_key [2];
   logic [3:0] m_fifo [2][4];
   int         m_cnt [2];
   int         m_acc [2];

   always #5 clk = ~clk;

   keypad_matrix_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(P)) dut0 (
      .clk(clk), .rst_n(rst_n), .rows_in(rows_in), .cols_out(cols_o[0]),
      .cmd_valid(cmd_valid), .cmd_key(cmd_key), .cmd_ready(rdy_o[0]), .flush(flush),
      .busy(busy_o[0]), .active_key(ak_o[0]), .contact(contact_o[0]), .key_done(kd_o[0]));

   keypad_matrix_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .BOUNCE_CYCLES(6), .BOUNCE_PERIOD(P)) dut1 (
      .clk(clk), .rst_n(rst_n), .rows_in(rows_in), .cols_out(cols_o[1]),
      .cmd_valid(cmd_valid), .cmd_key(cmd_key), .cmd_ready(rdy_o[1]), .flush(flush),
      .busy(busy_o[1]), .active_key(ak_o[1]), .contact(contact_o[1]), .key_done(kd_o[1]));

   function automatic int bval(int i);
      return (i == 0) ? 0 : 6;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_in[i]  = 1'b0;
         m_t[i]   = 0;
         m_key[i] = 4'd0;
         m_cnt[i] = 0;
      end
   endtask

   task automatic model_step();
      int  b;
      logic acc;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_in[i] = 1'b0; m_t[i] = 0; m_key[i] = 4'd0; m_cnt[i] = 0;
         end else begin
            b   = bval(i);
            acc = cmd_valid && (m_cnt[i] < 4) && !flush;
            if (m_acc[i] >= 0 && acc) m_acc[i]++;
            if (m_in[i]) begin
               if (flush && m_t[i] < b + H) m_t[i] = b + H;
               else if (m_t[i] == b + H + G - 1) m_in[i] = 1'b0;
               else m_t[i]++;
            end else if (m_cnt[i] > 0 && !flush) begin
               m_in[i]  = 1'b1;
               m_t[i]   = 0;
               m_key[i] = m_fifo[i][0];
               for (int k = 0; k < 3; k++) m_fifo[i][k] = m_fifo[i][k+1];
               m_cnt[i]--;
            end
            if (!m_in[i]) m_key[i] = 4'd0;
            if (flush) m_cnt[i] = 0;
            if (acc) begin
               m_fifo[i][m_cnt[i]] = cmd_key;
               m_cnt[i]++;
            end
         end
      end
   endtask

   function automatic logic [11:0] exp_vec(int i);
      logic c, kd, b, r;
      logic [3:0] ak, cols;
      int bc, t;
      bc   = bval(i);
      t    = m_t[i];
      c    = m_in[i] && ((t < bc) ? ((t / P) % 2 == 0) : (t < bc + H));
      kd   = m_in[i] && (t == bc + H + G - 1);
      b    = m_in[i] || (m_cnt[i] > 0);
      ak   = m_in[i] ? m_key[i] : 4'd0;
      r    = (m_cnt[i] < 4) && !flush;
      cols = 4'hF;
      if (c && rows_in[ak[3:2]] == 1'b0) cols[ak[1:0]] = 1'b0;
      return {c, kd, b, ak, r, cols};
   endfunction

   function automatic logic [11:0] obs_vec(int i);
      return {contact_o[i], kd_o[i], busy_o[i], ak_o[i], rdy_o[i], cols_o[i]};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      model_reset();
      repeat (2) begin
         #1;
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
               n_fail++;
               $display("FAIL reset_state dut%0d cycle %0d: got %h want %h", i, cyc, obs_vec(i), exp_vec(i));
            end
         end
         tick();
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_press(input logic [3:0] rows, input int want_low);
      int low_cnt, kd_cnt;
      low_cnt = 0; kd_cnt = 0;
      rows_in = rows;
      for (int n = 0; n < 20; n++) begin
         cmd_valid = (n == 0);
         cmd_key   = 4'd6;
         #1;
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
               n_fail++;
               $display("FAIL single_press dut%0d cycle %0d: got %h want %h", i, cyc, obs_vec(i), exp_vec(i));
            end
         end
         if (cols_o[0] == 4'b1011) low_cnt++;
         if (kd_o[0]) kd_cnt++;
         tick();
      end
      n_checks++;
      if (low_cnt !== want_low) begin
         n_fail++;
         $display("FAIL single_press_low_cycles: got %0d want %0d", low_cnt, want_low);
      end
      n_checks++;
      if (kd_cnt !== 1) begin
         n_fail++;
         $display("FAIL single_press_key_done: got %0d want 1", kd_cnt);
      end
   endtask

   task automatic test_bounce();
      logic [13:0] seq;
      seq = '0;
      rows_in = 4'b1110;
      for (int n = 0; n < 26; n++) begin
         cmd_valid = (n == 0);
         cmd_key   = 4'd0;
         #1;
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
               n_fail++;
               $display("FAIL bounce dut%0d cycle %0d: got %h want %h", i, cyc, obs_vec(i), exp_vec(i));
            end
         end
         if (n >= 2 && n < 16) seq = {seq[12:0], contact_o[1]};
         tick();
      end
      n_checks++;
      if (seq !== 14'b11001111111111) begin
         n_fail++;
         $display("FAIL bounce_pattern: got %b want %b", seq, 14'b11001111111111);
      end
   endtask

   task automatic test_back_to_back();
      int kd_cnt [2];
      kd_cnt[0] = 0; kd_cnt[1] = 0;
      m_acc[0] = 0; m_acc[1] = 0;
      rows_in = 4'b0000;
      for (int n = 0; n < 130; n++) begin
         cmd_valid = (n < 6);
         cmd_key   = 4'($urandom_range(0, 15));
         #1;
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
               n_fail++;
               $display("FAIL back_to_back dut%0d cycle %0d: got %h want %h", i, cyc, obs_vec(i), exp_vec(i));
            end
            if (kd_o[i]) kd_cnt[i]++;
         end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (kd_cnt[i] !== m_acc[i] || m_acc[i] != 5) begin
            n_fail++;
            $display("FAIL back_to_back_done_count dut%0d: got %0d done for %0d accepted, want 5", i, kd_cnt[i], m_acc[i]);
         end
      end
   endtask

   task automatic test_flush();
      rows_in = 4'($urandom_range(0, 15));
      for (int n = 0; n < 30; n++) begin
         cmd_valid = (n < 3) || (n == 5);
         cmd_key   = 4'($urandom_range(0, 15));
         flush     = (n == 5);
         #1;
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
               n_fail++;
               $display("FAIL flush dut%0d cycle %0d: got %h want %h", i, cyc, obs_vec(i), exp_vec(i));
            end
         end
         tick();
      end
      flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (busy_o[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle dut%0d: busy got %b want 0", i, busy_o[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      rows_in = 4'b1101;
      for (int n = 0; n < 5; n++) begin
         cmd_valid = (n == 0);
         cmd_key   = 4'd6;
         tick();
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (obs_vec(i) !== exp_vec(i) || cols_o[i] !== 4'b1111 || busy_o[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset dut%0d: got %h want %h", i, obs_vec(i), exp_vec(i));
         end
      end
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      test_single_press(4'b1101, 8);
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         cmd_valid = ($urandom_range(0, 3) == 0);
         cmd_key   = 4'($urandom_range(0, 15));
         flush     = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 3) == 0) rows_in = 4'($urandom_range(0, 15));
         #1;
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
               n_fail++;
               $display("FAIL random dut%0d cycle %0d: got %h want %h", i, cyc, obs_vec(i), exp_vec(i));
            end
         end
         tick();
      end
      cmd_valid = 1'b0;
      flush     = 1'b0;
   endtask

   initial begin
      m_acc[0] = -1; m_acc[1] = -1;
      model_reset();
      test_reset();
      test_single_press(4'b1101, 8);
      test_single_press(4'b1110, 0);
      test_bounce();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
